// File: rtl/demux1xn_pkg.sv
// Shared constants, types and helpers for the registered 1-to-N stream demux.
// Optional feature macro: DEMUX1XN_CNT_EN (per-channel output transfer counters).
package demux1xn_pkg;

    localparam int unsigned DEMUX1XN_DATA_W = 8;
    localparam int unsigned DEMUX1XN_N_CH   = 4;
    localparam int unsigned DEMUX1XN_CNT_W  = 16;

    // Occupancy of a one-entry output register.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    // Select width: max(1, clog2(n)), so two channels still get one select bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux1xn_if.sv
// Producer/consumer bus of the registered 1-to-N demux.
// Optional feature macro: DEMUX1XN_CNT_EN adds cnt/cnt_clr.
interface demux1xn_if
    import demux1xn_pkg::*;
#(
    parameter int unsigned DATA_W = DEMUX1XN_DATA_W,
    parameter int unsigned N_CH   = DEMUX1XN_N_CH,
    parameter int unsigned CNT_W  = DEMUX1XN_CNT_W
);

    localparam int unsigned SEL_W = sel_w(N_CH);

    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic                   err;
    logic                   err_clr;
`ifdef DEMUX1XN_CNT_EN
    logic [N_CH*CNT_W-1:0]  cnt;
    logic                   cnt_clr;
`endif

    if (DATA_W < 1 || N_CH < 2 || CNT_W < 1) begin : g_param_err
        $error("demux1xn_if: illegal parameters");
    end

    // Producer side plus the per-channel consumers (testbench / system glue).
    modport master (
        output in_data, in_sel, in_valid, out_ready, err_clr,
`ifdef DEMUX1XN_CNT_EN
        output cnt_clr,
        input  cnt,
`endif
        input  in_ready, out_data, out_valid, err
    );

    // The demux itself.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready, err_clr,
`ifdef DEMUX1XN_CNT_EN
        input  cnt_clr,
        output cnt,
`endif
        output in_ready, out_data, out_valid, err
    );

endinterface

// File: rtl/demux1xn_slot.sv
// One-entry output register with valid/ready handshake for a single channel.
// Optional feature macro: DEMUX1XN_CNT_EN adds a wrapping output transfer counter.
module demux1xn_slot
    import demux1xn_pkg::*;
#(
`ifdef DEMUX1XN_CNT_EN
    parameter int unsigned CNT_W  = DEMUX1XN_CNT_W,
`endif
    parameter int unsigned DATA_W = DEMUX1XN_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
`ifdef DEMUX1XN_CNT_EN
   ,input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  cnt_o
`endif
);

    ch_state_e         state_q;
    logic [DATA_W-1:0] data_q;
    logic              pop;

    assign pop     = (state_q == CH_FULL) && ready_i;
    assign valid_o = (state_q == CH_FULL);
    assign data_o  = data_q;

    // Occupancy FSM: a load wins over a pop, so push+pop keeps the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else if (load_i) begin
            state_q <= CH_FULL;
            data_q  <= data_i;
        end else if (pop) begin
            state_q <= CH_EMPTY;
        end
    end

`ifdef DEMUX1XN_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear beats increment; the counter wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output transfer counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux1xn_reg.sv
// Registered, flow-controlled 1-to-N stream demultiplexer: select decode,
// in_ready mux and sticky out-of-range error; channels live in demux1xn_slot.
// Optional feature macro: DEMUX1XN_CNT_EN (per-channel output transfer counters).
module demux1xn_reg
    import demux1xn_pkg::*;
#(
    parameter int unsigned DATA_W = DEMUX1XN_DATA_W,
    parameter int unsigned N_CH   = DEMUX1XN_N_CH,
    parameter int unsigned CNT_W  = DEMUX1XN_CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    demux1xn_if.slave bus
);

    localparam int unsigned SEL_W = sel_w(N_CH);

    if (DATA_W < 1 || N_CH < 2 || CNT_W < 1) begin : g_param_err
        $error("demux1xn_reg: illegal parameters");
    end

    logic [SEL_W-1:0]  sel;
    logic [31:0]       sel_ext;
    logic              in_range;
    logic              in_ready;
    logic [N_CH-1:0]   load;
    logic [N_CH-1:0]   valid;
    logic              err_q;
    logic              err_d;

    assign sel = bus.in_sel;

    // Decode the select; out-of-range selects match no channel and are always accepted.
    always_comb begin
        sel_ext  = 32'(sel);
        in_range = (sel_ext < N_CH);
        in_ready = 1'b1;
        load     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (sel_ext == k) begin
                in_ready = !valid[k] || bus.out_ready[k];
                load[k]  = bus.in_valid && (!valid[k] || bus.out_ready[k]);
            end
        end
    end

    // A new out-of-range acceptance outranks a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (bus.in_valid && !in_range) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.err       = err_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        demux1xn_slot #(
`ifdef DEMUX1XN_CNT_EN
            .CNT_W  (CNT_W),
`endif
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_i    (load[k]),
            .data_i    (bus.in_data),
            .ready_i   (bus.out_ready[k]),
            .valid_o   (valid[k]),
            .data_o    (bus.out_data[k*DATA_W +: DATA_W])
`ifdef DEMUX1XN_CNT_EN
           ,.cnt_clr_i (bus.cnt_clr),
            .cnt_o     (bus.cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_demux1xn_reg.sv
// Directed bench for demux1xn_reg: a 4-channel instance for routing, stall,
// streaming and reset, and a 5-channel instance for out-of-range select handling.
// Counter checks are built only when DEMUX1XN_CNT_EN is defined.
module tb_demux1xn_reg;

    logic clk;
    logic rst_n;

    int unsigned n_tests;
    int unsigned n_fail;

    demux1xn_if #(.DATA_W(8), .N_CH(4), .CNT_W(4)) a_if ();
    demux1xn_if #(.DATA_W(8), .N_CH(5), .CNT_W(4)) b_if ();

    demux1xn_reg #(.DATA_W(8), .N_CH(4), .CNT_W(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    demux1xn_reg #(.DATA_W(8), .N_CH(5), .CNT_W(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;

        a_if.in_data = '0; a_if.in_sel = '0; a_if.in_valid = 1'b0;
        a_if.out_ready = '0; a_if.err_clr = 1'b0;
        b_if.in_data = '0; b_if.in_sel = '0; b_if.in_valid = 1'b0;
        b_if.out_ready = '0; b_if.err_clr = 1'b0;
`ifdef DEMUX1XN_CNT_EN
        a_if.cnt_clr = 1'b0;
        b_if.cnt_clr = 1'b0;
`endif

        // Reset state
        tick(); tick();
        check("rst_valid_a", 64'(a_if.out_valid), 64'h0);
        check("rst_data_a",  64'(a_if.out_data),  64'h0);
        check("rst_err_a",   64'(a_if.err),       64'h0);
        check("rst_valid_b", 64'(b_if.out_valid), 64'h0);
        a_if.in_sel = 2'd2;
        #1;
        check("rst_ready_sel2", 64'(a_if.in_ready), 64'h1);
`ifdef DEMUX1XN_CNT_EN
        check("rst_cnt_a", 64'(a_if.cnt), 64'h0);
`endif
        rst_n = 1'b1;
        tick();

        // Push 0xA5 to channel 3 with every consumer stalled
        a_if.in_sel = 2'd3; a_if.in_data = 8'hA5; a_if.in_valid = 1'b1;
        #1;
        check("push3_ready", 64'(a_if.in_ready), 64'h1);
        tick();
        a_if.in_valid = 1'b0;
        check("push3_valid", 64'(a_if.out_valid), 64'h8);
        check("push3_data",  64'(a_if.out_data[31:24]), 64'hA5);

        // Second push to the full, stalled channel is refused
        a_if.in_data = 8'hEE; a_if.in_valid = 1'b1;
        #1;
        check("full3_ready", 64'(a_if.in_ready), 64'h0);
        tick();
        check("full3_hold_data",  64'(a_if.out_data[31:24]), 64'hA5);
        check("full3_hold_valid", 64'(a_if.out_valid), 64'h8);

        // A different channel is still open
        a_if.in_sel = 2'd1; a_if.in_data = 8'h11;
        #1;
        check("push1_ready", 64'(a_if.in_ready), 64'h1);
        tick();
        check("push1_valid", 64'(a_if.out_valid), 64'hA);
        check("push1_data",  64'(a_if.out_data[15:8]), 64'h11);

        // Fill channel 2, then push and pop it in the same cycle
        a_if.in_sel = 2'd2; a_if.in_data = 8'h77;
        tick();
        check("push2_valid", 64'(a_if.out_valid), 64'hE);
        a_if.out_ready = 4'b0100; a_if.in_data = 8'h3C;
        #1;
        check("pushpop2_ready", 64'(a_if.in_ready), 64'h1);
        tick();
        check("pushpop2_valid", 64'(a_if.out_valid), 64'hE);
        check("pushpop2_data",  64'(a_if.out_data[23:16]), 64'h3C);

        // Back-to-back stream of 8 words into channel 2
        for (int i = 0; i < 8; i++) begin
            a_if.in_data = 8'(8'h40 + i);
            #1;
            check("stream_ready", 64'(a_if.in_ready), 64'h1);
            tick();
            check("stream_data", 64'(a_if.out_data[23:16]), 64'(8'h40 + i));
        end
        a_if.in_valid = 1'b0;
        check("stream_hold_other", 64'({a_if.out_data[31:24], a_if.out_data[15:8]}), 64'hA511);
        tick();
        check("drain2_valid", 64'(a_if.out_valid), 64'hA);
        a_if.out_ready = 4'b1111;
        tick();
        check("drain_all_valid", 64'(a_if.out_valid), 64'h0);
`ifdef DEMUX1XN_CNT_EN
        check("cnt_after_stream", 64'(a_if.cnt), 64'h1A10);
`endif

        // in_valid low never loads a channel
        a_if.out_ready = 4'b0000; a_if.in_sel = 2'd0; a_if.in_data = 8'h99;
        tick();
        check("idle_no_load", 64'(a_if.out_valid), 64'h0);

        // Out-of-range select on the 5-channel instance
        b_if.in_sel = 3'd6; b_if.in_data = 8'hDE; b_if.in_valid = 1'b1;
        #1;
        check("oor_ready", 64'(b_if.in_ready), 64'h1);
        tick();
        b_if.in_valid = 1'b0;
        check("oor_err",   64'(b_if.err),       64'h1);
        check("oor_valid", 64'(b_if.out_valid), 64'h0);
        b_if.in_sel = 3'd7; b_if.in_valid = 1'b1; b_if.err_clr = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check("oor_err_prio", 64'(b_if.err), 64'h1);
        tick();
        b_if.err_clr = 1'b0;
        check("err_clr", 64'(b_if.err), 64'h0);

        // Highest legal channel of a non-power-of-two instance
        b_if.in_sel = 3'd4; b_if.in_data = 8'h5A; b_if.in_valid = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        check("ch4_valid", 64'(b_if.out_valid), 64'h10);
        check("ch4_data",  64'(b_if.out_data[39:32]), 64'h5A);
        check("ch4_err",   64'(b_if.err), 64'h0);

`ifdef DEMUX1XN_CNT_EN
        // 17 pops on channel 0 wrap a 4-bit counter to 1
        a_if.cnt_clr = 1'b1;
        tick();
        a_if.cnt_clr = 1'b0;
        a_if.out_ready = 4'b0001; a_if.in_sel = 2'd0; a_if.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_if.in_data = 8'(i);
            tick();
        end
        a_if.in_valid = 1'b0;
        tick();
        check("cnt_wrap", 64'(a_if.cnt[3:0]), 64'h1);
        a_if.out_ready = 4'b0000; a_if.in_valid = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        a_if.out_ready = 4'b0001; a_if.cnt_clr = 1'b1;
        tick();
        a_if.cnt_clr = 1'b0;
        check("cnt_clr_prio", 64'(a_if.cnt[3:0]), 64'h0);
        check("cnt_clr_popped", 64'(a_if.out_valid), 64'h0);
        a_if.out_ready = 4'b0000;
`endif

        // Fill all four channels, then assert reset between edges
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.in_sel  = 2'(i);
            a_if.in_data = 8'(8'hC0 + i);
            tick();
        end
        a_if.in_valid = 1'b0;
        check("fill_all_valid", 64'(a_if.out_valid), 64'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(a_if.out_valid), 64'h0);
        check("async_rst_data",  64'(a_if.out_data),  64'h0);
        check("async_rst_b",     64'(b_if.out_valid), 64'h0);
        tick();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1xn_reg.md
# demux1xn_reg

Registered, parametrised 1-to-N stream demultiplexer. It routes one DATA_W-bit input word per accepted transfer to the output channel chosen by a binary select. Each channel has its own valid/ready handshake and a one-entry output register, so a stalled channel does not block traffic to the others. It sits between a single producer and N independent consumers, and is the clocked, flow-controlled, N-way generalisation of the team's combinational 1x4 demux.

## Interface
- DATA_W, 8: payload width in bits (≥1).
- N_CH, 4: number of output channels (≥2; need not be a power of two).
- CNT_W, 16: per-channel transfer counter width; used only with DEMUX1XN_CNT_EN.
- SEL_W (localparam): max(1, $clog2(N_CH)).
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_data  in  DATA_W: input payload.
- in_sel  in  SEL_W: destination channel index.
- in_valid  in  1: input word present.
- in_ready  out  1: block accepts the word this cycle.
- out_data  out  N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  N_CH: per-channel word present.
- out_ready  in  N_CH: per-channel consumer accept.
- err  out  1: sticky flag, set when a word with in_sel ≥ N_CH is accepted.
- err_clr  in  1: synchronous clear of err.
- cnt  out  N_CH*CNT_W: per-channel accepted-output counters (present only with DEMUX1XN_CNT_EN).
- cnt_clr  in  1: synchronous clear of all counters (present only with DEMUX1XN_CNT_EN).

## Operation
- Each channel k is a 2-state register: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- Input transfer occurs when in_valid && in_ready.
- When in_sel < N_CH: in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is combinational and depends on in_sel and the selected channel's state and ready only.
- When in_sel ≥ N_CH: in_ready = 1. The word is dropped, no channel changes, and err is set.
- On an accepted in-range word, channel in_sel loads in_data and goes FULL.
- Output transfer on channel k occurs when out_valid[k] && out_ready[k]. The channel goes EMPTY unless it is reloaded in the same cycle.
- Simultaneous pop and push on the same channel: the new word is loaded and out_valid[k] stays 1, giving full throughput.
- Non-selected channels hold data and valid and drain independently. All N channels may pop in the same cycle.
- out_data[k] is stable while out_valid[k] && !out_ready[k].
- in_valid=0 changes no channel, regardless of in_sel.
- err has priority: err_clr and a new out-of-range acceptance in the same cycle leave err = 1.

## Timing
- Reset values: out_valid = 0, out_data = 0, err = 0, cnt = 0. in_ready then depends only on in_sel.
- Reset asserted mid-operation: all held words are discarded immediately (asynchronous).
- Latency: a word accepted at edge t is visible on out_data/out_valid after edge t. One cycle, no bypass.
- Throughput: one word per cycle into any channel whose consumer holds out_ready=1.
- Combinational paths: in_sel, out_ready → in_ready. No path from in_data or in_valid to any output.

## Configuration
- DEMUX1XN_CNT_EN defined:
  - cnt/cnt_clr ports exist.
  - cnt[k] increments on each output transfer of channel k and wraps modulo 2^CNT_W.
  - cnt_clr takes priority over an increment in the same cycle.
- DEMUX1XN_CNT_EN undefined: cnt/cnt_clr ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Package demux1xn_pkg holds the default DATA_W/N_CH/CNT_W constants, the SEL_W derivation function, and the channel state enum (CH_EMPTY, CH_FULL).
- One sub-module is natural: demux1xn_slot, the one-entry register with valid/ready (and optional counter), instantiated N_CH times by a generate loop. The top level contains select decode, the in_ready mux and err.

## Test plan
- Reset with all inputs idle → out_valid=0, out_data=0, err=0. in_sel=2 → in_ready=1.
- N_CH=4, push 0xA5 to sel 3 with out_ready=4'b0000 → next cycle out_valid=4'b1000, out_data[31:24]=0xA5. A second push to sel 3 sees in_ready=0; a push to sel 1 is accepted.
- Channel 2 FULL, out_ready[2]=1, push 0x3C to sel 2 in the same cycle → in_ready=1 and out_valid[2] stays 1 with data 0x3C. Back-to-back streaming of 8 words gives 8 outputs in 8 cycles.
- N_CH=5, SEL_W=3, in_sel=6, in_valid=1 → in_ready=1, err=1 next cycle, no out_valid change. err_clr together with in_sel=7, in_valid=1 → err stays 1.
- Channels 0–3 FULL, assert rst_n=0 mid-cycle → out_valid=0 immediately (before the next edge).
- With DEMUX1XN_CNT_EN and CNT_W=4: 17 pops on channel 0 → cnt[3:0]=1. cnt_clr together with a pop → 0.
